// File: rtl/core_pkg.sv
// Shared types and exception cause codes for the per-hart sequencing controller.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WFI   = 3'd3,
        TRAP  = 3'd4
    } ctrl_state_e;

    localparam logic [3:0] EXC_INSTR_FAULT = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_BREAK       = 4'd3;
    localparam logic [3:0] EXC_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] EXC_STORE_FAULT = 4'd7;
    localparam logic [3:0] EXC_ECALL_U     = 4'd8;
    localparam logic [3:0] EXC_ECALL_S     = 4'd9;
    localparam logic [3:0] EXC_ECALL_M     = 4'd11;

endpackage

// File: rtl/core_controller.sv
// Per-hart sequencer: one instruction in flight through FETCH/EXEC/MEM, with
// trap diversion, WFI parking, latched trap cause and a retire strobe.
module core_controller
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic       fetch_stage_valid,
    input  logic       fetch_stage_ready,
    input  logic       ex_instr_access_fault,
    output logic       exec_stage_valid,
    input  logic       exec_is_mem,
    input  logic       exec_is_wfi,
    input  logic       exec_ex_valid,
    input  logic [3:0] exec_ex_code,
    output logic       mem_stage_valid,
    input  logic       mem_stage_ready,
    input  logic       mem_is_store,
    input  logic       mem_err,
    input  logic       m_interrupt_valid,
    input  logic       s_interrupt_valid,
    input  logic       wfi_wakeup,
    output logic       trap_valid,
    output logic       trap_is_interrupt,
    output logic [3:0] trap_code,
    output logic       retire
);

    ctrl_state_e state_reg;
    ctrl_state_e state_next;
    logic        trap_take;
    logic        trap_int_next;
    logic [3:0]  trap_code_next;
    logic        trap_int_reg;
    logic [3:0]  trap_code_reg;

    // Strobes are pure decodes of state and inputs so they drop with reset.
    always_comb begin
        state_next        = state_reg;
        trap_take         = 1'b0;
        trap_int_next     = 1'b0;
        trap_code_next    = 4'd0;
        fetch_stage_valid = 1'b0;
        exec_stage_valid  = 1'b0;
        mem_stage_valid   = 1'b0;
        trap_valid        = 1'b0;
        retire            = 1'b0;
        case (state_reg)
            FETCH: begin
                fetch_stage_valid = 1'b1;
                if (m_interrupt_valid || s_interrupt_valid) begin
                    state_next    = TRAP;
                    trap_take     = 1'b1;
                    trap_int_next = 1'b1;
                end else if (fetch_stage_ready && ex_instr_access_fault) begin
                    state_next     = TRAP;
                    trap_take      = 1'b1;
                    trap_code_next = EXC_INSTR_FAULT;
                end else if (fetch_stage_ready) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                exec_stage_valid = 1'b1;
                if (exec_ex_valid) begin
                    state_next     = TRAP;
                    trap_take      = 1'b1;
                    trap_code_next = exec_ex_code;
                end else if (exec_is_mem) begin
                    state_next = MEM;
                end else begin
                    retire     = 1'b1;
                    state_next = exec_is_wfi ? WFI : FETCH;
                end
            end
            MEM: begin
                mem_stage_valid = 1'b1;
                if (mem_stage_ready && mem_err) begin
                    state_next     = TRAP;
                    trap_take      = 1'b1;
                    trap_code_next = mem_is_store ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                end else if (mem_stage_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            WFI: begin
                if (wfi_wakeup) begin
                    state_next = FETCH;
                end
            end
            TRAP: begin
                trap_valid = 1'b1;
                state_next = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= FETCH;
            trap_int_reg  <= 1'b0;
            trap_code_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            if (trap_take) begin
                trap_int_reg  <= trap_int_next;
                trap_code_reg <= trap_code_next;
            end
        end
    end

    assign trap_is_interrupt = trap_int_reg;
    assign trap_code         = trap_code_reg;

endmodule
